// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: serialises MEM-stage (C) and DMA/debug (D) accesses,
// sequences reads through a fixed memory latency and stalls the pipeline while
// the C access is outstanding.
module dmem_arbiter #(
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_write,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    input  logic [3:0]  c_xfer,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [63:0] c_rdata,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [3:0]  d_xfer,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_write,
    output logic        mem_read,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_xfer,
    input  logic [63:0] mem_rdata
);

    localparam logic [2:0] LatInit   = 3'(READ_LAT);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    typedef enum logic {StIdle, StWait} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;   // 1 = port D owns the outstanding read
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  xfer_q, xfer_d;

    logic        gnt_c, gnt_d, win_write;

    // State register with synchronous reset; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            lat_q    <= 3'd0;
            starve_q <= 4'd0;
            addr_q   <= 64'd0;
            xfer_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            xfer_q   <= xfer_d;
        end
    end

    // Arbitration, memory command mux, read sequencing and output gating.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        xfer_d    = xfer_q;
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        win_write = 1'b0;
        c_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        c_rdata   = 64'd0;
        c_stall   = 1'b0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = 64'd0;
        mem_addr  = 64'd0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_wdata = 64'd0;
        mem_xfer  = 4'd0;

        case (state_q)
            StIdle: begin
                // A starved D overrides the normal C priority.
                if (d_req && (!c_req || starve_q == StarveMax)) begin
                    gnt_d = 1'b1;
                end else if (c_req) begin
                    gnt_c = 1'b1;
                end
                if (gnt_c || gnt_d) begin
                    win_write = gnt_d ? d_write : c_write;
                    mem_addr  = gnt_d ? d_addr  : c_addr;
                    mem_wdata = gnt_d ? d_wdata : c_wdata;
                    mem_xfer  = gnt_d ? d_xfer  : c_xfer;
                    mem_write = win_write;
                    mem_read  = ~win_write;
                    if (!win_write) begin
                        if (LatInit == 3'd0) begin
                            c_rvalid = gnt_c;
                            d_rvalid = gnt_d;
                            c_rdata  = gnt_c ? mem_rdata : 64'd0;
                            d_rdata  = gnt_d ? mem_rdata : 64'd0;
                        end else begin
                            state_d = StWait;
                            owner_d = gnt_d;
                            lat_d   = LatInit;
                            addr_d  = mem_addr;
                            xfer_d  = mem_xfer;
                        end
                    end
                end
            end
            StWait: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                mem_xfer = xfer_q;
                lat_d    = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    c_rvalid = ~owner_q;
                    d_rvalid = owner_q;
                    c_rdata  = owner_q ? 64'd0 : mem_rdata;
                    d_rdata  = owner_q ? mem_rdata : 64'd0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        c_gnt = gnt_c;
        d_gnt = gnt_d;

        if (gnt_d || !d_req) begin
            starve_d = 4'd0;
        end else if (starve_q >= StarveMax) begin
            starve_d = StarveMax;
        end else begin
            starve_d = starve_q + 4'd1;
        end

        c_stall = c_req & ~(c_gnt & c_write) & ~c_rvalid;

        if (reset) begin
            c_gnt     = 1'b0;
            c_rvalid  = 1'b0;
            c_rdata   = 64'd0;
            c_stall   = 1'b0;
            d_gnt     = 1'b0;
            d_rvalid  = 1'b0;
            d_rdata   = 64'd0;
            mem_addr  = 64'd0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            mem_wdata = 64'd0;
            mem_xfer  = 4'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (READ_LAT 1, 3, 0) share the same stimulus;
// each is checked every cycle against a per-instance occupancy model, plus
// directed constant checks for the key scenarios.
module tb_dmem_arbiter;

    localparam int NI = 3;
    localparam int unsigned LIM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        c_req, c_write, d_req, d_write;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]  c_xfer, d_xfer;

    logic        o_cg [NI], o_cv [NI], o_cs [NI], o_dg [NI], o_dv [NI];
    logic        o_mw [NI], o_mr [NI];
    logic [63:0] o_cr [NI], o_dr [NI], o_ma [NI], o_mwd [NI];
    logic [3:0]  o_mx [NI];
    wire  [266:0] act [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned RL = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        dmem_arbiter #(.READ_LAT(RL), .STARVE_LIMIT(LIM)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .c_req    (c_req),
            .c_write  (c_write),
            .c_addr   (c_addr),
            .c_wdata  (c_wdata),
            .c_xfer   (c_xfer),
            .c_gnt    (o_cg[g]),
            .c_rvalid (o_cv[g]),
            .c_rdata  (o_cr[g]),
            .c_stall  (o_cs[g]),
            .d_req    (d_req),
            .d_write  (d_write),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_xfer   (d_xfer),
            .d_gnt    (o_dg[g]),
            .d_rvalid (o_dv[g]),
            .d_rdata  (o_dr[g]),
            .mem_addr (o_ma[g]),
            .mem_write(o_mw[g]),
            .mem_read (o_mr[g]),
            .mem_wdata(o_mwd[g]),
            .mem_xfer (o_mx[g]),
            .mem_rdata(mem_rdata)
        );
        assign act[g] = {o_cg[g], o_cv[g], o_cr[g], o_cs[g], o_dg[g], o_dv[g], o_dr[g],
                         o_ma[g], o_mw[g], o_mr[g], o_mwd[g], o_mx[g]};
    end

    int tests = 0;
    int fails = 0;

    // Reference model: busy = cycles of WAIT still to go after the grant cycle.
    int          lat_of [NI] = '{1, 3, 0};
    int          busy   [NI];
    int          starve [NI];
    bit          own    [NI];
    logic [63:0] cap_a  [NI];
    logic [3:0]  cap_x  [NI];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, compare all instances, advance the model.
    task automatic cmp();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            logic cg, cv, cs, dg, dv, mw, mr, wr;
            logic [63:0] cr, dr, ma, mwd;
            logic [3:0] mx;
            logic [266:0] e;
            int win;
            cg = 0; cv = 0; cs = 0; dg = 0; dv = 0; mw = 0; mr = 0; wr = 0;
            cr = 0; dr = 0; ma = 0; mwd = 0; mx = 0; win = -1;
            if (reset) begin
                busy[k] = 0; starve[k] = 0; own[k] = 0;
            end else begin
                if (busy[k] > 0) begin
                    mr = 1; ma = cap_a[k]; mx = cap_x[k];
                    if (busy[k] == 1) begin
                        if (own[k]) begin dv = 1; dr = mem_rdata; end
                        else begin cv = 1; cr = mem_rdata; end
                    end
                    busy[k]--;
                end else begin
                    if (d_req && (!c_req || starve[k] == LIM)) win = 1;
                    else if (c_req) win = 0;
                    if (win >= 0) begin
                        wr  = (win == 1) ? d_write : c_write;
                        ma  = (win == 1) ? d_addr : c_addr;
                        mwd = (win == 1) ? d_wdata : c_wdata;
                        mx  = (win == 1) ? d_xfer : c_xfer;
                        mw = wr; mr = !wr;
                        if (win == 1) dg = 1; else cg = 1;
                        if (!wr) begin
                            if (lat_of[k] == 0) begin
                                if (win == 1) begin dv = 1; dr = mem_rdata; end
                                else begin cv = 1; cr = mem_rdata; end
                            end else begin
                                busy[k] = lat_of[k]; own[k] = (win == 1);
                                cap_a[k] = ma; cap_x[k] = mx;
                            end
                        end
                    end
                end
                cs = c_req && !(cg && c_write) && !cv;
                if (dg || !d_req) starve[k] = 0;
                else if (starve[k] < LIM) starve[k]++;
            end
            e = {cg, cv, cr, cs, dg, dv, dr, ma, mw, mr, mwd, mx};
            tests++;
            assert (act[k] === e) else begin
                fails++;
                $error("FAIL model[%0d] observed=%h expected=%h", k, act[k], e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic req, input logic wr, input logic [63:0] a);
        c_req = req; c_write = wr; c_addr = a; c_wdata = a ^ 64'h5555; c_xfer = 4'd8;
    endtask

    task automatic set_d(input logic req, input logic wr, input logic [63:0] a);
        d_req = req; d_write = wr; d_addr = a; d_wdata = a ^ 64'hAAAA; d_xfer = 4'd4;
    endtask

    task automatic idle(input int n);
        set_c(0, 0, 0); set_d(0, 0, 0);
        for (int i = 0; i < n; i++) begin cmp(); tick(); end
    endtask

    initial begin
        reset = 1; mem_rdata = 0;
        set_c(0, 0, 0); set_d(0, 0, 0);
        for (int i = 0; i < NI; i++) begin
            busy[i] = 0; starve[i] = 0; own[i] = 0; cap_a[i] = 0; cap_x[i] = 0;
        end
        cmp(); tick();
        c_req = 1; d_req = 1;      // outputs must stay 0 under reset
        cmp();
        chk("rst_cstall", {63'd0, o_cs[0]}, 0);
        chk("rst_gnt", {62'd0, o_cg[0], o_dg[0]}, 0);
        tick();
        reset = 0;
        idle(2);

        // C load, READ_LAT=1 (instance 0)
        set_c(1, 0, 64'h10); mem_rdata = 64'h0;
        cmp();
        chk("ld1_gnt", {63'd0, o_cg[0]}, 1);
        chk("ld1_mrd", {63'd0, o_mr[0]}, 1);
        chk("ld1_addr", o_ma[0], 64'h10);
        chk("ld1_stall0", {63'd0, o_cs[0]}, 1);
        tick();
        mem_rdata = 64'hAB;
        cmp();
        chk("ld1_rvalid", {63'd0, o_cv[0]}, 1);
        chk("ld1_rdata", o_cr[0], 64'hAB);
        chk("ld1_stall1", {63'd0, o_cs[0]}, 0);
        tick();
        idle(4);

        // Simultaneous stores: C first, D the cycle after C drops
        set_c(1, 1, 64'h20); set_d(1, 1, 64'h28);
        cmp();
        chk("both_cgnt", {63'd0, o_cg[0]}, 1);
        chk("both_dgnt", {63'd0, o_dg[0]}, 0);
        chk("both_addr", o_ma[0], 64'h20);
        tick();
        set_c(0, 0, 0);
        cmp();
        chk("both_dlater", {63'd0, o_dg[0]}, 1);
        tick();
        idle(2);

        // Starvation override with continuous C stores
        set_c(1, 1, 64'h30); set_d(1, 1, 64'h38);
        for (int k = 0; k < 10; k++) begin
            cmp();
            chk($sformatf("starve_dgnt%0d", k), {63'd0, o_dg[0]}, (k == 4 || k == 9) ? 1 : 0);
            if (k == 4) chk("starve_cstall", {63'd0, o_cs[0]}, 1);
            tick();
        end
        idle(2);

        // D load, READ_LAT=3 (instance 1), C store raised mid-WAIT
        set_d(1, 0, 64'h40);
        cmp();
        chk("dld_gnt", {63'd0, o_dg[1]}, 1);
        tick();
        set_c(1, 1, 64'h50);
        for (int k = 1; k <= 3; k++) begin
            mem_rdata = 64'hD000 + 64'(k);
            cmp();
            chk($sformatf("dld_cgnt%0d", k), {63'd0, o_cg[1]}, 0);
            chk($sformatf("dld_cstall%0d", k), {63'd0, o_cs[1]}, 1);
            chk($sformatf("dld_rv%0d", k), {63'd0, o_dv[1]}, (k == 3) ? 1 : 0);
            tick();
        end
        set_d(0, 0, 0);
        cmp();
        chk("dld_cafter", {63'd0, o_cg[1]}, 1);
        tick();
        idle(4);

        // Reset in the second WAIT cycle of a C load (instance 1)
        set_c(1, 0, 64'h60);
        cmp(); chk("rstw_gnt", {63'd0, o_cg[1]}, 1); tick();
        cmp(); tick();
        reset = 1;
        cmp(); chk("rstw_zero", {63'd0, |act[1]}, 0); tick();
        reset = 0; set_c(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cmp(); chk($sformatf("rstw_norv%0d", k), {63'd0, o_cv[1]}, 0); tick();
        end

        // READ_LAT=0 (instance 2): same-cycle completion and back-to-back grant
        set_c(1, 0, 64'h70); mem_rdata = 64'h77;
        cmp();
        chk("l0_gnt", {63'd0, o_cg[2]}, 1);
        chk("l0_rv", {63'd0, o_cv[2]}, 1);
        chk("l0_rdata", o_cr[2], 64'h77);
        chk("l0_stall", {63'd0, o_cs[2]}, 0);
        tick();
        set_c(1, 0, 64'h78);
        cmp();
        chk("l0_gnt2", {63'd0, o_cg[2]}, 1);
        chk("l0_addr2", o_ma[2], 64'h78);
        tick();
        idle(4);

        // Randomised traffic checked against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_c($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom});
            set_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom});
            c_xfer = 4'($urandom); d_xfer = 4'($urandom);
            mem_rdata = {$urandom, $urandom};
            cmp();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
